// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one full-adder cell plus a carry flop.
// {cout,sum} = a + b + cin after WIDTH steps, shown with a one-cycle done.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             s_bit;
  logic             c_nxt;
  logic             last;
  logic [WIDTH-1:0] acc_sh;

  always_comb begin
    s_bit  = a_q[0] ^ b_q[0] ^ c_q;
    c_nxt  = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));
    // new sum bit enters at the MSB; after WIDTH steps bit 0 is the LSB
    acc_sh = (acc_q >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));
    last   = (cnt_q == CW'(WIDTH - 1));

    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    cout_d  = cout_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          c_d     = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = acc_sh;
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        c_d   = c_nxt;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          sum_d   = acc_sh;
          cout_d  = c_nxt;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder at WIDTH=8 and WIDTH=1: timeline model
// compared every cycle, plus directed vectors with literal results.
module tb_serial_adder;

  logic       clk;
  logic       rst_n;
  logic [1:0] st;
  logic [1:0] cin_s;
  logic [7:0] a_s [2];
  logic [7:0] b_s [2];

  logic       busy8, done8, cout8;
  logic [7:0] sum8;
  logic       busy1, done1, cout1;
  logic [0:0] sum1;

  logic       dbusy [2];
  logic       ddone [2];
  logic       dcout [2];
  logic [7:0] dsum  [2];

  int tests;
  int fails;
  int dcnt [2];
  bit chk_en;

  // model state
  bit         mb [2];
  bit         md [2];
  int         mt [2];
  logic [8:0] mp [2];
  logic [8:0] mres [2];

  serial_adder #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .start(st[0]),
    .a(a_s[0]), .b(b_s[0]), .cin(cin_s[0]),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .start(st[1]),
    .a(a_s[1][0]), .b(b_s[1][0]), .cin(cin_s[1]),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  always_comb begin
    dbusy[0] = busy8;
    dbusy[1] = busy1;
    ddone[0] = done8;
    ddone[1] = done1;
    dcout[0] = cout8;
    dcout[1] = cout1;
    dsum[0]  = sum8;
    dsum[1]  = {7'b0, sum1};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wof(input int k);
    return (k == 0) ? 8 : 1;
  endfunction

  function automatic logic [8:0] ref_add(input int w,
      input logic [7:0] a, input logic [7:0] b, input logic c);
    logic [8:0] m;
    m = (9'd1 << w) - 9'd1;
    return ({1'b0, a} & m) + ({1'b0, b} & m) + {8'b0, c};
  endfunction

  function automatic logic [8:0] res_of(input int k);
    return ({8'b0, dcout[k]} << wof(k)) | {1'b0, dsum[k]};
  endfunction

  task automatic chk(input string nm, input int k,
      input logic [8:0] act, input logic [8:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s (w%0d) at %0t: got %h want %h",
        nm, wof(k), $time, act, exp);
    end
  endtask

  // timeline model: done on the W-th edge after accept, idle one later
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        mb[k]   <= 1'b0;
        md[k]   <= 1'b0;
        mt[k]   <= 0;
        mres[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (!mb[k]) begin
          if (st[k]) begin
            mb[k] <= 1'b1;
            mt[k] <= 0;
            mp[k] <= ref_add(wof(k), a_s[k], b_s[k], cin_s[k]);
          end
        end else begin
          mt[k] <= mt[k] + 1;
          if (mt[k] == wof(k) - 1) begin
            mres[k] <= mp[k];
            md[k]   <= 1'b1;
          end else if (mt[k] == wof(k)) begin
            mb[k] <= 1'b0;
            md[k] <= 1'b0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk("busy", k, {8'b0, dbusy[k]}, {8'b0, mb[k]});
        chk("done", k, {8'b0, ddone[k]}, {8'b0, md[k]});
        chk("result", k, res_of(k), mres[k]);
        if (ddone[k]) dcnt[k]++;
      end
    end
  end

  task automatic run_op(input int k, input logic [7:0] a,
      input logic [7:0] b, input logic c, input logic [8:0] exp,
      input int lat, input int hold);
    int n;
    bit got;
    n = 0;
    got = 0;
    @(posedge clk);
    #1;
    st[k] = 1'b1;
    a_s[k] = a;
    b_s[k] = b;
    cin_s[k] = c;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      n++;
      #1;
      st[k] = 1'b0;
      a_s[k] = 8'($urandom);
      b_s[k] = 8'($urandom);
      if (ddone[k]) begin
        got = 1;
        break;
      end
      if (hold >= 0) chk("hold", k, res_of(k), 9'(hold));
    end
    chk("done_seen", k, {8'b0, got}, 9'd1);
    if (got) begin
      chk("sum_lit", k, res_of(k), exp);
      if (lat > 0) chk("latency", k, 9'(n), 9'(lat));
    end
    @(posedge clk);
    #1;
  endtask

  logic [1:0] fa_tab [8];
  int d0;

  initial begin
    fa_tab = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    tests = 0;
    fails = 0;
    dcnt[0] = 0;
    dcnt[1] = 0;
    chk_en = 0;
    rst_n = 1'b1;
    st = '0;
    cin_s = '0;
    a_s[0] = '0; a_s[1] = '0;
    b_s[0] = '0; b_s[1] = '0;
    #2 rst_n = 1'b0;
    chk_en = 1;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_busy", k, {8'b0, dbusy[k]}, 9'd0);
      chk("rst_done", k, {8'b0, ddone[k]}, 9'd0);
      chk("rst_res", k, res_of(k), 9'd0);
    end
    rst_n = 1'b1;

    // WIDTH=1 full-adder truth table
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      run_op(1, {7'b0, v[2]}, {7'b0, v[1]}, v[0],
        {7'b0, fa_tab[i]}, 2, -1);
    end

    // WIDTH=8 directed additions
    run_op(0, 8'hFF, 8'h01, 1'b0, 9'h100, 9, -1);
    run_op(0, 8'hA5, 8'h5A, 1'b1, 9'h100, 9, -1);
    run_op(0, 8'h3C, 8'h42, 1'b0, 9'h07E, 9, -1);
    // previous result held through the run
    run_op(0, 8'h01, 8'h01, 1'b0, 9'h002, 9, 9'h07E);

    // start ignored while busy
    d0 = dcnt[0];
    @(posedge clk);
    #1;
    st[0] = 1'b1;
    a_s[0] = 8'h10;
    b_s[0] = 8'h20;
    cin_s[0] = 1'b0;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk);
      #1;
      a_s[0] = 8'hFF;
      b_s[0] = 8'hFF;
      st[0] = (c == 2 || c == 8);
      if (c == 10) chk("idle_after", 0, {8'b0, dbusy[0]}, 9'd0);
    end
    chk("one_done", 0, 9'(dcnt[0] - d0), 9'd1);
    chk("ign_res", 0, res_of(0), 9'h030);

    // reset abort mid-run
    d0 = dcnt[0];
    @(posedge clk);
    #1;
    st[0] = 1'b1;
    a_s[0] = 8'hFF;
    b_s[0] = 8'hFF;
    cin_s[0] = 1'b1;
    @(posedge clk);
    #1;
    st[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 0, {8'b0, dbusy[0]}, 9'd0);
    chk("abort_done", 0, {8'b0, ddone[0]}, 9'd0);
    chk("abort_res", 0, res_of(0), 9'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("abort_nodone", 0, 9'(dcnt[0] - d0), 9'd0);
    run_op(0, 8'h01, 8'h02, 1'b0, 9'h003, 9, -1);

    // back-to-back with start held high
    d0 = dcnt[0];
    @(posedge clk);
    #1;
    st[0] = 1'b1;
    a_s[0] = 8'h01;
    b_s[0] = 8'h01;
    cin_s[0] = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (i == 9) chk("b2b_gap", 0, {8'b0, dbusy[0]}, 9'd0);
      if (i == 10) chk("b2b_acc", 0, {8'b0, dbusy[0]}, 9'd1);
    end
    st[0] = 1'b0;
    chk("b2b_dones", 0, 9'(dcnt[0] - d0), 9'd3);
    chk("b2b_res", 0, res_of(0), 9'h002);
    repeat (4) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
